// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : byte-serial 8N1/8N2 UART transmitter with req/cts handshake.
// rev 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CYCLES_PER_BIT = 3,
  parameter int STOP_BITS      = 1
) (
  input  logic       clock,
  input  logic       i_rstn,
  input  logic [7:0] i_data,
  input  logic       i_req,
  output logic       o_serial,
  output logic       o_cts,
  output logic       o_idle
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             bit_end;

  assign bit_end = (cycle_cnt == CNT_LAST);

  // bit_cnt indexes data bits in DATA and is reused to count stop bits in STOP
  always_ff @(posedge clock) begin
    if (!i_rstn) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            shift     <= i_data;
            cycle_cnt <= '0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            state     <= DATA;
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            shift     <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_cts    = (state == IDLE);
  assign o_idle   = (state == IDLE);
  assign o_serial = (state == DATA) ? shift[0] : (state != START);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// tb_uart_tx : two transmitter configurations checked every cycle against a
// frame-position model, plus a line receiver and hand-computed frame literals.
`default_nettype none

module tb_uart_tx;

  localparam int CPB0 = 3, SB0 = 1, CPB1 = 1, SB1 = 2;
  localparam int LEN0 = (9 + SB0) * CPB0;
  localparam int LEN1 = (9 + SB1) * CPB1;

  logic       clock = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_req = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       ser0, cts0, idl0, ser1, cts1, idl1;

  uart_tx #(.CYCLES_PER_BIT(CPB0), .STOP_BITS(SB0)) dut0 (
    .clock(clock), .i_rstn(i_rstn), .i_data(i_data), .i_req(i_req),
    .o_serial(ser0), .o_cts(cts0), .o_idle(idl0));

  uart_tx #(.CYCLES_PER_BIT(CPB1), .STOP_BITS(SB1)) dut1 (
    .clock(clock), .i_rstn(i_rstn), .i_data(i_data), .i_req(i_req),
    .o_serial(ser1), .o_cts(cts1), .o_idle(idl1));

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: t = cycles since the accept edge (-1 when idle); a frame of
  // (9+stop_bits) bits is {stop ones, data LSB first, start zero}.
  int         t0 = -1, t1 = -1;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic [7:0] done_q[$];
  logic [7:0] rx_q[$];

  function automatic logic exp_line(input int t, input logic [7:0] d, input int cpb);
    logic [10:0] f;
    if (t < 0) return 1'b1;
    f = {2'b11, d, 1'b0};
    return f[t / cpb];
  endfunction

  always @(posedge clock) begin
    if (!i_rstn) begin
      t0 = -1;
      t1 = -1;
    end else begin
      if (t0 >= 0) begin
        t0++;
        if (t0 == LEN0) begin
          done_q.push_back(d0);
          t0 = -1;
        end
      end else if (i_req) begin
        t0 = 0;
        d0 = i_data;
      end
      if (t1 >= 0) begin
        t1++;
        if (t1 == LEN1) t1 = -1;
      end else if (i_req) begin
        t1 = 0;
        d1 = i_data;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      check("serial0", ser0, exp_line(t0, d0, CPB0));
      check("cts0",    cts0, (t0 < 0));
      check("idle0",   idl0, (t0 < 0));
      check("serial1", ser1, exp_line(t1, d1, CPB1));
      check("cts1",    cts1, (t1 < 0));
      check("idle1",   idl1, (t1 < 0));
    end
  end

  // Line receiver on dut0, sampling mid-bit
  int         rx_t = -1;
  logic [7:0] rx_b = 8'h00;
  always @(negedge clock) begin
    int k;
    if (!i_rstn) rx_t = -1;
    else if (rx_t < 0) begin
      if (chk_on && ser0 == 1'b0) rx_t = 0;
    end else rx_t++;
    if (rx_t >= 0 && (rx_t % CPB0) == CPB0 / 2) begin
      k = rx_t / CPB0;
      if (k == 0) check("rx_start", ser0, 0);
      else if (k <= 8) rx_b[k-1] = ser0;
      else begin
        check("rx_stop", ser0, 1);
        rx_q.push_back(rx_b);
        rx_t = -1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cts0 && cts1) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    i_data = b;
    i_req  = 1'b1;
    tick();
    i_req  = 1'b0;
  endtask

  logic       s[70];
  logic       c[70];
  logic [9:0] w;
  logic [10:0] v;
  int         busy, idx, n0, n;

  initial begin
    // reset and quiet line
    i_rstn = 1'b0;
    tick(2);
    chk_on = 1'b1;
    @(negedge clock);
    check("rst_serial", ser0, 1);
    check("rst_cts", cts0, 1);
    check("rst_idle", idl0, 1);
    tick();
    i_rstn = 1'b1;
    tick(20);

    // 0x48 with defaults
    wait_idle();
    send(8'h48);
    for (int i = 0; i < 31; i++) begin
      @(negedge clock);
      s[i] = ser0;
      c[i] = cts0;
    end
    busy = 0;
    for (int i = 0; i < 30; i++) if (!c[i]) busy++;
    check("busy_len_48", busy, 30);
    check("cts_back_48", c[30], 1);
    for (int k = 0; k < 10; k++) w[k] = s[3*k+1];
    check("frame_48", w, 10'h290);

    // back-to-back 0x55 then 0xAA with req held
    wait_idle();
    i_data = 8'h55;
    i_req  = 1'b1;
    tick();
    i_data = 8'hAA;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      s[i] = ser0;
    end
    i_req = 1'b0;
    idx = -1;
    for (int i = 69; i >= 27; i--) if (s[i] == 1'b0) idx = i;
    check("b2b_first_start", s[0], 0);
    check("b2b_second_start", idx, 31);
    for (int k = 0; k < 10; k++) w[k] = s[31+3*k+1];
    check("frame_AA", w, 10'h354);
    wait_idle();

    // request pulse and data change mid-frame are ignored
    wait_idle();
    n0 = rx_q.size();
    send(8'h3C);
    tick(8);
    i_data = 8'hC3;
    i_req  = 1'b1;
    tick(2);
    i_req  = 1'b0;
    i_data = 8'h00;
    wait_idle();
    check("midframe_count", rx_q.size() - n0, 1);
    check("midframe_byte", rx_q[rx_q.size()-1], 8'h3C);

    // reset during data bit 3, then a clean frame
    wait_idle();
    send(8'h5A);
    tick(12);
    i_rstn = 1'b0;
    tick();
    @(negedge clock);
    check("abort_serial", ser0, 1);
    check("abort_cts", cts0, 1);
    tick();
    i_rstn = 1'b1;
    n0 = rx_q.size();
    send(8'h81);
    wait_idle();
    check("after_rst_count", rx_q.size() - n0, 1);
    check("after_rst_byte", rx_q[rx_q.size()-1], 8'h81);

    // 8N2 at one cycle per bit
    wait_idle();
    send(8'hFF);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      s[i] = ser1;
      c[i] = cts1;
    end
    busy = 0;
    for (int i = 0; i < 11; i++) begin
      v[i] = s[i];
      if (!c[i]) busy++;
    end
    check("frame_FF_8N2", v, 11'h7FE);
    check("busy_len_FF", busy, 11);
    check("cts_back_FF", c[11], 1);

    // 512 random bytes with random req behaviour while busy
    wait_idle();
    n0 = rx_q.size();
    for (int b = 0; b < 512; b++) begin
      n = 0;
      while (!cts0 && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) check("rand_wait_timeout", 0, 1);
      i_data = 8'($urandom);
      i_req  = 1'b1;
      tick();
      i_req  = 1'($urandom_range(0, 1));
      i_data = 8'($urandom);
      tick($urandom_range(0, 2));
    end
    i_req = 1'b0;
    wait_idle();
    tick(5);
    check("rand_rx_count", rx_q.size() - n0, 512);
    check("rx_vs_model_count", rx_q.size(), done_q.size());
    for (int i = 0; i < rx_q.size() && i < done_q.size(); i++)
      check("rx_byte", rx_q[i], done_q[i]);
    check("final_line_high", ser0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
